hhmm_timekeeper: RTL and testbench

//  Upstream time source for the 4-digit 7-segment display driver. Holds the

---
 rtl/hhmm_timekeeper.sv | 185 ++++++++++++++++++
 tb/tb_hhmm_timekeeper.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hhmm_timekeeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hhmm_timekeeper: BCD HH:MM:SS time of day with debounced set buttons      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module hhmm_timekeeper #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] h10,
  output logic [3:0] h01,
  output logic [3:0] m10,
  output logic [3:0] m01,
  output logic [3:0] s10,
  output logic [3:0] s01,
  output logic [1:0] mode,
  output logic       blink,
  output logic       sec_pulse
);

  localparam int unsigned     c_PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned     c_DW        = $clog2(DB_CYCLES + 1);
  localparam logic [c_PW-1:0] c_TICK_LAST = c_PW'(TICK_DIV - 1);
  localparam logic [c_PW-1:0] c_HALF      = c_PW'(TICK_DIV / 2);
  localparam logic [c_DW-1:0] c_DB_LAST   = c_DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  logic [1:0] w_btn_raw;
  logic [1:0] w_evt;
  logic       w_mode_evt;
  logic       w_inc_evt;

  assign w_btn_raw = {btn_inc, btn_mode};

  // Each button: 2-FF synchronizer, then a counter that must see the new level
  // for DB_CYCLES consecutive cycles before the stable level follows it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic            r_s1;
      logic            r_s2;
      logic            r_stable;
      logic            r_evt;
      logic [c_DW-1:0] r_cnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_s1     <= 1'b0;
          r_s2     <= 1'b0;
          r_stable <= 1'b0;
          r_evt    <= 1'b0;
          r_cnt    <= '0;
        end else begin
          r_s1  <= w_btn_raw[gi];
          r_s2  <= r_s1;
          r_evt <= 1'b0;
          if (r_s2 == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
            r_evt    <= r_s2;
          end else begin
            r_cnt <= r_cnt + c_DW'(1);
          end
        end
      end

      assign w_evt[gi] = r_evt;
    end
  endgenerate

  assign w_mode_evt = w_evt[0];
  assign w_inc_evt  = w_evt[1];

  function automatic logic [7:0] f_hour_inc(input logic [3:0] t, input logic [3:0] u);
    if (t >= 4'd2 && u >= 4'd3) return 8'h00;
    else if (u >= 4'd9)         return {t + 4'd1, 4'd0};
    else                        return {t, u + 4'd1};
  endfunction

  function automatic logic [7:0] f_sexa_inc(input logic [3:0] t, input logic [3:0] u);
    if (u >= 4'd9) return (t >= 4'd5) ? 8'h00 : {t + 4'd1, 4'd0};
    else           return {t, u + 4'd1};
  endfunction

  state_t          r_state, w_state_next;
  logic [c_PW-1:0] r_presc, w_presc_next;
  logic            w_tick;
  logic [3:0]      r_h10, r_h01, r_m10, r_m01, r_s10, r_s01;
  logic [3:0]      w_h10, w_h01, w_m10, w_m01, w_s10, w_s01;
  logic            w_sec;
  logic            r_sec;
  logic            r_blink;

  assign w_tick = (r_presc == c_TICK_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:     if (w_mode_evt) w_state_next = ST_SET_HR;
      ST_SET_HR:  if (w_mode_evt) w_state_next = ST_SET_MIN;
      ST_SET_MIN: if (w_mode_evt) w_state_next = ST_RUN;
      default:    w_state_next = ST_RUN;
    endcase
  end

  // Leaving SET_MIN restarts the second so a full second elapses before the first tick.
  always_comb begin
    w_presc_next = r_presc + c_PW'(1);
    if ((r_state == ST_SET_MIN && w_mode_evt) || w_tick) w_presc_next = '0;
  end

  always_comb begin
    w_h10 = r_h10;
    w_h01 = r_h01;
    w_m10 = r_m10;
    w_m01 = r_m01;
    w_s10 = r_s10;
    w_s01 = r_s01;
    w_sec = 1'b0;
    if (r_state == ST_RUN && w_tick && !w_mode_evt) begin
      w_sec          = 1'b1;
      {w_s10, w_s01} = f_sexa_inc(r_s10, r_s01);
      if (r_s10 >= 4'd5 && r_s01 >= 4'd9) begin
        {w_m10, w_m01} = f_sexa_inc(r_m10, r_m01);
        if (r_m10 >= 4'd5 && r_m01 >= 4'd9) {w_h10, w_h01} = f_hour_inc(r_h10, r_h01);
      end
    end else if (r_state == ST_SET_HR && w_inc_evt && !w_mode_evt) begin
      {w_h10, w_h01} = f_hour_inc(r_h10, r_h01);
    end else if (r_state == ST_SET_MIN && w_inc_evt && !w_mode_evt) begin
      {w_m10, w_m01} = f_sexa_inc(r_m10, r_m01);
    end else if (r_state == ST_SET_MIN && w_mode_evt) begin
      w_s10 = 4'd0;
      w_s01 = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_presc <= '0;
      r_h10   <= 4'd0;
      r_h01   <= 4'd0;
      r_m10   <= 4'd0;
      r_m01   <= 4'd0;
      r_s10   <= 4'd0;
      r_s01   <= 4'd0;
      r_sec   <= 1'b0;
      r_blink <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_presc <= w_presc_next;
      r_h10   <= w_h10;
      r_h01   <= w_h01;
      r_m10   <= w_m10;
      r_m01   <= w_m01;
      r_s10   <= w_s10;
      r_s01   <= w_s01;
      r_sec   <= w_sec;
      r_blink <= (w_state_next == ST_SET_HR || w_state_next == ST_SET_MIN) &&
                 (w_presc_next < c_HALF);
    end
  end

  assign h10       = r_h10;
  assign h01       = r_h01;
  assign m10       = r_m10;
  assign m01       = r_m01;
  assign s10       = r_s10;
  assign s01       = r_s01;
  assign mode      = r_state;
  assign blink     = r_blink;
  assign sec_pulse = r_sec;

endmodule
`default_nettype wire

// File: tb/tb_hhmm_timekeeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hhmm_timekeeper: self-checking bench for hhmm_timekeeper               |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_hhmm_timekeeper;

  localparam logic [25:0] c_ALL = 26'h3FF_FFFF;
  localparam logic [25:0] c_HM  = {16'hFFFF, 8'h00, 2'b11};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] h10, h01, m10, m01, s10, s01;
  logic [1:0] mode;
  logic       blink, sec_pulse;

  hhmm_timekeeper #(.TICK_DIV(10), .DB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .h10(h10), .h01(h01), .m10(m10), .m01(m01), .s10(s10), .s01(s01),
    .mode(mode), .blink(blink), .sec_pulse(sec_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [25:0] val;
    logic [25:0] mask;
  } exp_t;

  typedef struct {
    bit         do_mode;
    int         n_inc;
    logic [3:0] eh10, eh01, em10, em01;
    logic [1:0] emode;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   failures = 0;
  int   blink_in_run = 0;

  function automatic logic [25:0] sod_vec(input int sod, input logic [1:0] md);
    int hh, mm, ss;
    hh = sod / 3600;
    mm = (sod / 60) % 60;
    ss = sod % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
            4'(ss / 10), 4'(ss % 10), md};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input string name, input logic [25:0] val, input logic [25:0] mask);
    exp_t e;
    e.name = name;
    e.val  = val;
    e.mask = mask;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [25:0] act;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard: output observed with no expectation queued");
      return;
    end
    e   = exp_q.pop_front();
    act = {h10, h01, m10, m01, s10, s01, mode};
    if ((act & e.mask) !== (e.val & e.mask)) begin
      failures++;
      $display("FAIL %s: got %h%h:%h%h:%h%h mode=%b, expected %h%h:%h%h:%h%h mode=%b (mask %h)",
               e.name, h10, h01, m10, m01, s10, s01, mode,
               e.val[25:22], e.val[21:18], e.val[17:14], e.val[13:10],
               e.val[9:6], e.val[5:2], e.val[1:0], e.mask);
    end
  endtask

  task automatic press(input bit m, input bit i);
    btn_mode = m;
    btn_inc  = i;
    step(6);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(8);
  endtask

  // Expected second count for every pulse is queued up front, then popped as pulses arrive.
  task automatic run_pulses(input int n, input int start_sod);
    int gap;
    for (int k = 1; k <= n; k++)
      push_exp($sformatf("tick%0d", k), sod_vec((start_sod + k) % 86400, 2'b00), c_ALL);
    for (int k = 1; k <= n; k++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
        if (blink) blink_in_run++;
      end while (!sec_pulse && gap < 20);
      check_int($sformatf("pulse_gap%0d", k), gap, 10);
      pop_check();
    end
  endtask

  task automatic mode_to_run(input string name, input int sod);
    int c;
    c = 0;
    btn_mode = 1'b1;
    push_exp(name, sod_vec(sod, 2'b00), c_ALL);
    do begin
      @(negedge clk);
      c++;
    end while (mode != 2'b00 && c < 30);
    btn_mode = 1'b0;
    pop_check();
  endtask

  task automatic apply_row(input int r);
    if (vecs[r].do_mode) press(1'b1, 1'b0);
    repeat (vecs[r].n_inc) press(1'b0, 1'b1);
    push_exp($sformatf("row%0d", r),
             {vecs[r].eh10, vecs[r].eh01, vecs[r].em10, vecs[r].em01, 8'h00, vecs[r].emode},
             c_HM);
    pop_check();
  endtask

  task automatic check_reset_state(input string name);
    push_exp(name, 26'h0, c_ALL);
    pop_check();
    check_int({name, "_blink"}, int'(blink), 0);
    check_int({name, "_sec"}, int'(sec_pulse), 0);
  endtask

  initial begin
    int highs, toggles, secs;
    logic prev;

    vecs[0] = '{1'b1,  0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b01};
    vecs[1] = '{1'b0, 23, 4'd2, 4'd3, 4'd0, 4'd0, 2'b01};
    vecs[2] = '{1'b0,  1, 4'd0, 4'd0, 4'd0, 4'd0, 2'b01};
    vecs[3] = '{1'b0,  1, 4'd0, 4'd1, 4'd0, 4'd0, 2'b01};
    vecs[4] = '{1'b1,  0, 4'd0, 4'd2, 4'd0, 4'd0, 2'b10};
    vecs[5] = '{1'b0, 59, 4'd0, 4'd2, 4'd5, 4'd9, 2'b10};
    vecs[6] = '{1'b0,  1, 4'd0, 4'd2, 4'd0, 4'd0, 2'b10};
    vecs[7] = '{1'b0,  1, 4'd0, 4'd2, 4'd0, 4'd1, 2'b10};

    step(3);
    check_reset_state("reset_state");
    reset = 1'b1;

    // Ten seconds from reset, one pulse every 10 cycles.
    run_pulses(10, 0);
    check_int("blink_in_run", blink_in_run, 0);

    // Hours setting, wrap 23->00.
    for (int r = 0; r < 4; r++) apply_row(r);

    highs = 0;
    toggles = 0;
    secs = 0;
    @(negedge clk);
    prev = blink;
    for (int k = 0; k < 20; k++) begin
      if (prev) highs++;
      if (sec_pulse) secs++;
      @(negedge clk);
      if (blink != prev) toggles++;
      prev = blink;
    end
    check_int("blink_high_cycles", highs, 10);
    check_int("blink_toggles", toggles, 4);
    check_int("sec_pulse_in_set", secs, 0);

    // Bounces shorter than the debounce window yield nothing; a steady hold yields one event.
    btn_inc = 1'b1; step(1); btn_inc = 1'b0; step(1);
    btn_inc = 1'b1; step(2); btn_inc = 1'b0; step(1);
    btn_inc = 1'b1; step(3); btn_inc = 1'b0; step(8);
    push_exp("bounce_short", {4'd0, 4'd1, 4'd0, 4'd0, 8'h00, 2'b01}, c_HM);
    pop_check();
    btn_inc = 1'b1; step(1); btn_inc = 1'b0; step(2);
    btn_inc = 1'b1; step(1); btn_inc = 1'b0; step(1);
    btn_inc = 1'b1; step(6); btn_inc = 1'b0; step(8);
    push_exp("bounce_hold", {4'd0, 4'd2, 4'd0, 4'd0, 8'h00, 2'b01}, c_HM);
    pop_check();

    // Minutes setting, 59->00 with no carry into hours.
    for (int r = 4; r < 8; r++) apply_row(r);

    mode_to_run("set_min_exit", 2 * 3600 + 1 * 60);
    run_pulses(1, 2 * 3600 + 1 * 60);

    // Preload 23:59 and roll over midnight.
    press(1'b1, 1'b0);
    repeat (21) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (58) press(1'b0, 1'b1);
    push_exp("preload", {4'd2, 4'd3, 4'd5, 4'd9, 8'h00, 2'b10}, c_HM);
    pop_check();
    mode_to_run("preload_run", 23 * 3600 + 59 * 60);
    run_pulses(60, 23 * 3600 + 59 * 60);

    // Simultaneous mode+inc: mode wins.
    press(1'b1, 1'b1);
    push_exp("both_run", {16'h0000, 8'h00, 2'b01}, c_HM);
    pop_check();
    press(1'b1, 1'b1);
    push_exp("both_set", {16'h0000, 8'h00, 2'b10}, c_HM);
    pop_check();

    // Reset in SET_MIN while a press is mid-debounce.
    btn_inc = 1'b1;
    step(3);
    reset = 1'b0;
    step(2);
    check_reset_state("reset_mid_set");
    btn_inc = 1'b0;
    step(2);
    reset = 1'b1;
    step(12);
    push_exp("post_reset", 26'h0, c_HM);
    pop_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
